// File: rtl/hdmi_period_scheduler.sv
// Raster timing and HDMI period sequencer: owns h/v counters, sync/CTL codes,
// guard bands, pixel enable, and grants data islands in horizontal blanking.
module hdmi_period_scheduler #(
  parameter int H_ACTIVE     = 640,
  parameter int H_FRONT      = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BACK       = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FRONT      = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BACK       = 33,
  parameter bit SYNC_ACTIVE  = 1'b0,
  parameter int ISLAND_START = 4
) (
  input  logic        tmds_clk,
  input  logic        n_rst,
  input  logic        island_req,
  input  logic [2:0]  island_num_pkts,
  output logic        island_grant,
  output logic        island_pkt_start,
  output logic [4:0]  island_clk_idx,
  output logic [1:0]  period_type,
  output logic        guard_band,
  output logic [1:0]  ctrl_ch0,
  output logic [1:0]  ctrl_ch1,
  output logic [1:0]  ctrl_ch2,
  output logic        de,
  output logic [11:0] h_pos,
  output logic [10:0] v_pos
);

  localparam int H_BLANK = H_FRONT + H_SYNC + H_BACK;
  localparam int H_TOTAL = H_ACTIVE + H_BLANK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [11:0] H_LAST  = 12'(H_TOTAL - 1);
  localparam logic [11:0] H_ACT   = 12'(H_ACTIVE);
  localparam logic [11:0] H_ADM   = 12'(H_ACTIVE + ISLAND_START);
  localparam logic [11:0] H_VPRE  = 12'(H_TOTAL - 10);
  localparam logic [11:0] H_VGB   = 12'(H_TOTAL - 2);
  localparam logic [11:0] H_HS0   = 12'(H_ACTIVE + H_FRONT);
  localparam logic [11:0] H_HS1   = 12'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [10:0] V_LAST  = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_ACT   = 11'(V_ACTIVE);
  localparam logic [10:0] V_VS0   = 11'(V_ACTIVE + V_FRONT);
  localparam logic [10:0] V_VS1   = 11'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic        SYNC_OFF = ~SYNC_ACTIVE;

  typedef enum logic [2:0] {
    S_CTRL, S_VID_PRE, S_VID_GB, S_VIDEO, S_DI_PRE, S_DI_LGB, S_DI_DATA, S_DI_TGB
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] h_q, h_d;
  logic [10:0] v_q, v_d, v_after;
  logic [2:0]  cnt_q, cnt_d;
  logic [4:0]  idx_q, idx_d;
  logic [2:0]  pkt_q, pkt_d;
  logic [2:0]  npk_q, npk_d;
  logic [2:0]  n_req;
  logic        next_act, fits, to_ctrl, grant_d, hs, vs;

  always_comb begin
    h_d = (h_q == H_LAST) ? '0 : h_q + 12'd1;
    v_d = v_q;
    if (h_q == H_LAST) v_d = (v_q == V_LAST) ? '0 : v_q + 11'd1;
    v_after  = (v_d == V_LAST) ? '0 : v_d + 11'd1;
    next_act = v_after < V_ACT;
    n_req    = (island_num_pkts == 3'd0) ? 3'd1 : island_num_pkts;
    fits     = (ISLAND_START + 16 + 32 * int'(n_req)) <= (H_BLANK - 10);
    hs       = (h_d >= H_HS0) && (h_d < H_HS1);
    vs       = (v_d >= V_VS0) && (v_d < V_VS1);

    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    pkt_d   = pkt_q;
    npk_d   = npk_q;
    grant_d = 1'b0;
    to_ctrl = 1'b0;

    case (state_q)
      S_CTRL:    to_ctrl = 1'b1;
      S_VID_PRE: if (h_d == H_VGB) state_d = S_VID_GB;
      S_VID_GB:  if (h_d == '0) state_d = S_VIDEO;
      S_VIDEO:   if (h_d == H_ACT) to_ctrl = 1'b1;
      S_DI_PRE: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = S_DI_LGB;
          cnt_d   = '0;
        end
      end
      S_DI_LGB: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = S_DI_DATA;
          idx_d   = '0;
          pkt_d   = '0;
        end
      end
      S_DI_DATA: begin
        idx_d = idx_q + 5'd1;
        if (idx_q == 5'd31) begin
          if (pkt_q == npk_q) begin
            state_d = S_DI_TGB;
            cnt_d   = '0;
          end else begin
            pkt_d = pkt_q + 3'd1;
          end
        end
      end
      S_DI_TGB: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd1) to_ctrl = 1'b1;
      end
      default:   to_ctrl = 1'b1;
    endcase

    // Any slot that would otherwise be control time is where islands and video preambles may start.
    if (to_ctrl) begin
      state_d = S_CTRL;
      if (h_d == H_ADM && island_req && fits) begin
        state_d = S_DI_PRE;
        cnt_d   = '0;
        npk_d   = n_req - 3'd1;
        grant_d = 1'b1;
      end else if (h_d == H_VPRE && next_act) begin
        state_d = S_VID_PRE;
      end
    end
  end

  always_ff @(posedge tmds_clk) begin
    if (!n_rst) begin
      state_q          <= S_CTRL;
      h_q              <= H_ACT;
      v_q              <= V_LAST;
      cnt_q            <= '0;
      idx_q            <= '0;
      pkt_q            <= '0;
      npk_q            <= '0;
      island_grant     <= 1'b0;
      island_pkt_start <= 1'b0;
      island_clk_idx   <= '0;
      period_type      <= 2'b00;
      guard_band       <= 1'b0;
      ctrl_ch0         <= {SYNC_OFF, SYNC_OFF};
      ctrl_ch1         <= 2'b00;
      ctrl_ch2         <= 2'b00;
      de               <= 1'b0;
    end else begin
      state_q          <= state_d;
      h_q              <= h_d;
      v_q              <= v_d;
      cnt_q            <= cnt_d;
      idx_q            <= idx_d;
      pkt_q            <= pkt_d;
      npk_q            <= npk_d;
      island_grant     <= grant_d;
      island_pkt_start <= (state_d == S_DI_DATA) && (idx_d == 5'd0);
      island_clk_idx   <= (state_d == S_DI_DATA) ? idx_d : '0;
      period_type      <= (state_d inside {S_DI_LGB, S_DI_DATA, S_DI_TGB}) ? 2'b01 :
                          (state_d inside {S_VID_GB, S_VIDEO})            ? 2'b10 : 2'b00;
      guard_band       <= state_d inside {S_VID_GB, S_DI_LGB, S_DI_TGB};
      ctrl_ch0         <= {vs ? SYNC_ACTIVE : SYNC_OFF, hs ? SYNC_ACTIVE : SYNC_OFF};
      ctrl_ch1         <= (state_d inside {S_VID_PRE, S_DI_PRE}) ? 2'b01 : 2'b00;
      ctrl_ch2         <= (state_d == S_DI_PRE) ? 2'b01 : 2'b00;
      de               <= state_d == S_VIDEO;
    end
  end

  assign h_pos = h_q;
  assign v_pos = v_q;

endmodule
